// File: rtl/alu_uart_sequencer.sv
// Frame sequencer: pops operand A, operand B and opcode from the RX FIFO, registers the ALU
// result and pushes it into the TX FIFO. Define SEQ_TIMEOUT_EN to enable the inter-byte timeout.
module alu_uart_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_FRAMES      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rxfifo_empty,
  input  logic [NB_DATA-1:0]   i_rxfifo_data,
  output logic                 o_rxfifo_pop,
  output logic [NB_DATA-1:0]   o_alu_a,
  output logic [NB_DATA-1:0]   o_alu_b,
  output logic [NB_OP-1:0]     o_alu_op,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_txfifo_full,
  output logic                 o_txfifo_push,
  output logic [NB_DATA-1:0]   o_txfifo_data,
  output logic                 o_busy,
  output logic [NB_FRAMES-1:0] o_frame_cnt,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  state_t               state_reg;
  logic [NB_DATA-1:0]   a_reg;
  logic [NB_DATA-1:0]   b_reg;
  logic [NB_OP-1:0]     op_reg;
  logic [NB_DATA-1:0]   result_reg;
  logic [NB_FRAMES-1:0] frame_cnt_reg;

  logic mid_frame;
  logic in_get;
  logic pop_w;
  logic push_w;
  logic abort_w;

  assign mid_frame = (state_reg == GET_B) || (state_reg == GET_OP);
  assign in_get    = (state_reg == GET_A) || mid_frame;

  // Strobes are qualified by reset so they read 0 while the block is held in reset.
  assign pop_w  = i_reset && in_get && !i_rxfifo_empty;
  assign push_w = i_reset && (state_reg == SEND) && !i_txfifo_full;

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_reg;
  logic             timeout_reg;

  assign abort_w = mid_frame && !pop_w && (to_cnt_reg == CNT_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= abort_w;
      if (pop_w || !mid_frame || abort_w)
        to_cnt_reg <= '0;
      else
        to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign o_timeout = timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign abort_w   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= GET_A;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      result_reg    <= '0;
      frame_cnt_reg <= '0;
    end else begin
      case (state_reg)
        GET_A: begin
          if (pop_w) begin
            a_reg     <= i_rxfifo_data;
            state_reg <= GET_B;
          end
        end
        GET_B: begin
          if (pop_w) begin
            b_reg     <= i_rxfifo_data;
            state_reg <= GET_OP;
          end else if (abort_w) begin
            state_reg <= GET_A;
          end
        end
        GET_OP: begin
          if (pop_w) begin
            op_reg    <= i_rxfifo_data[NB_OP-1:0];
            state_reg <= EXEC;
          end else if (abort_w) begin
            state_reg <= GET_A;
          end
        end
        EXEC: begin
          result_reg <= i_alu_result;
          state_reg  <= SEND;
        end
        SEND: begin
          if (push_w) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
            state_reg     <= GET_A;
          end
        end
        default: state_reg <= GET_A;
      endcase
    end
  end

  assign o_rxfifo_pop  = pop_w;
  assign o_txfifo_push = push_w;
  assign o_alu_a       = a_reg;
  assign o_alu_b       = b_reg;
  assign o_alu_op      = op_reg;
  assign o_txfifo_data = result_reg;
  assign o_busy        = (state_reg != GET_A);
  assign o_frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer: FIFO and ALU models plus a frame-level reference.
`timescale 1ns/1ps
module tb_alu_uart_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       tx_full = 1'b0;
  logic       tx_push;
  logic [7:0] tx_data;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(
    .NB_DATA(8), .NB_OP(6), .NB_FRAMES(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_rxfifo_empty(rx_empty), .i_rxfifo_data(rx_data), .o_rxfifo_pop(rx_pop),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_result(alu_result),
    .i_txfifo_full(tx_full), .o_txfifo_push(tx_push), .o_txfifo_data(tx_data),
    .o_busy(busy), .o_frame_cnt(frame_cnt), .o_timeout(timeout)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return $signed(a) >>> b[2:0];
      default: return a;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

  // RX FIFO model (first-word fall-through ring) and bus monitor.
  logic [7:0] rx_mem [0:255];
  int rx_wr = 0;
  int rx_rd = 0;
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_data  = rx_mem[rx_rd[7:0]];

  int cycle = 0;
  int pop_cnt = 0;
  int bad_pop = 0;
  int push_cnt = 0;
  int last_pop_cycle = 0;
  logic [7:0] tx_log [0:2047];
  int tx_cyc [0:2047];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rx_pop) begin
      if (rx_empty) bad_pop <= bad_pop + 1;
      pop_cnt        <= pop_cnt + 1;
      rx_rd          <= rx_rd + 1;
      last_pop_cycle <= cycle;
    end
    if (tx_push) begin
      tx_log[push_cnt[10:0]] <= tx_data;
      tx_cyc[push_cnt[10:0]] <= cycle;
      push_cnt <= push_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_mem[rx_wr[7:0]] = b;
    rx_wr = rx_wr + 1;
  endtask

  task automatic wait_push(input int target, input int budget, input string name);
    int n = 0;
    while (push_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (push_cnt < target) begin
      n_fail++;
      $display("FAIL %s: push count %0d, required %0d within %0d cycles", name, push_cnt, target, budget);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, rx_pop, tx_push, timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/pop/push/timeout=%b required 0000", {busy, rx_pop, tx_push, timeout});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_alu: a=%h b=%h op=%h required 0", alu_a, alu_b, alu_op);
    end
    n_checks++;
    if (tx_data !== 8'h00 || frame_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: txdata=%h frames=%h required 0", tx_data, frame_cnt);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pop_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b pops=%0d required 0 0", busy, pop_cnt);
    end
    exp_frames = 0;
  endtask

  task automatic test_basic();
    int p0 = pop_cnt;
    int t0 = push_cnt;
    send_byte(8'h81); send_byte(8'h7E); send_byte(8'h20);
    wait_push(t0 + 1, 20, "basic_wait");
    exp_frames++;
    n_checks++;
    if (pop_cnt - p0 != 3) begin
      n_fail++;
      $display("FAIL basic_pops: %0d pops, required 3", pop_cnt - p0);
    end
    n_checks++;
    if (alu_a !== 8'h81 || alu_b !== 8'h7E || alu_op !== 6'h20) begin
      n_fail++;
      $display("FAIL basic_operands: a=%h b=%h op=%h required 81 7e 20", alu_a, alu_b, alu_op);
    end
    n_checks++;
    if (tx_log[t0[10:0]] !== 8'hFF) begin
      n_fail++;
      $display("FAIL basic_result: pushed %h required ff", tx_log[t0[10:0]]);
    end
    n_checks++;
    if (tx_cyc[t0[10:0]] - last_pop_cycle != 2) begin
      n_fail++;
      $display("FAIL basic_latency: push %0d cycles after last pop, required 2", tx_cyc[t0[10:0]] - last_pop_cycle);
    end
    n_checks++;
    if (frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_frames: frame_cnt=%0d required 1", frame_cnt);
    end
  endtask

  task automatic test_rx_gaps();
    int t0 = push_cnt;
    logic [7:0] bytes [3];
    int p1;
    bytes[0] = 8'h81; bytes[1] = 8'h7E; bytes[2] = 8'h20;
    for (int k = 0; k < 3; k++) begin
      send_byte(bytes[k]);
      if (k < 2) begin
        repeat (2) @(negedge clk);
        p1 = pop_cnt;
        repeat (7) @(negedge clk);
        n_checks++;
        if (pop_cnt != p1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_%0d: pops during gap=%0d busy=%b required 0 1", k, pop_cnt - p1, busy);
        end
      end
    end
    wait_push(t0 + 1, 20, "gap_wait");
    exp_frames++;
    n_checks++;
    if (tx_log[t0[10:0]] !== 8'hFF || frame_cnt !== exp_frames[7:0]) begin
      n_fail++;
      $display("FAIL gap_result: data=%h frames=%0d required ff %0d", tx_log[t0[10:0]], frame_cnt, exp_frames[7:0]);
    end
  endtask

  task automatic test_backpressure();
    int t0 = push_cnt;
    logic [7:0] a, b, o, exp;
    int bad = 0;
    a = 8'($urandom); b = 8'($urandom); o = 8'h24;
    exp = alu_ref(a, b, o[5:0]);
    tx_full = 1'b1;
    send_byte(a); send_byte(b); send_byte(o);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (tx_push !== 1'b0 || tx_data !== exp || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0 || push_cnt != t0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d bad cycles, pushes=%0d data=%h required 0 0 %h", bad, push_cnt - t0, tx_data, exp);
    end
    tx_full = 1'b0;
    #1;
    n_checks++;
    if (tx_push !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: push=%b required 1", tx_push);
    end
    repeat (4) @(negedge clk);
    exp_frames++;
    n_checks++;
    if (push_cnt != t0 + 1 || tx_log[t0[10:0]] !== exp || frame_cnt !== exp_frames[7:0]) begin
      n_fail++;
      $display("FAIL bp_single: pushes=%0d data=%h frames=%0d required 1 %h %0d",
               push_cnt - t0, tx_log[t0[10:0]], frame_cnt, exp, exp_frames[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    int t0 = push_cnt;
    logic [7:0] exp [4];
    logic [7:0] a, b, o;
    int bad = 0;
    for (int f = 0; f < 4; f++) begin
      a = 8'($urandom); b = 8'($urandom);
      o = (f == 3) ? 8'hE0 : 8'($urandom_range(32, 39));
      exp[f] = alu_ref(a, b, o[5:0]);
      send_byte(a); send_byte(b); send_byte(o);
    end
    wait_push(t0 + 4, 40, "b2b_wait");
    exp_frames += 4;
    for (int f = 0; f < 4; f++) begin
      if (tx_log[(t0 + f) % 2048] !== exp[f]) bad++;
      if (f > 0 && tx_cyc[(t0 + f) % 2048] - tx_cyc[(t0 + f - 1) % 2048] != 5) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_frames: %0d data/spacing errors over 4 frames, required 0", bad);
    end
    n_checks++;
    if (alu_op !== 6'h20 || frame_cnt !== exp_frames[7:0]) begin
      n_fail++;
      $display("FAIL b2b_op: op=%h frames=%0d required 20 %0d", alu_op, frame_cnt, exp_frames[7:0]);
    end
  endtask

  task automatic test_random();
    int t0 = push_cnt;
    logic [7:0] exp [20];
    logic [7:0] bytes [3];
    int bad = 0;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          tx_full = ($urandom_range(0, 3) == 0);
        end
        bytes[k] = 8'($urandom);
        send_byte(bytes[k]);
      end
      exp[f] = alu_ref(bytes[0], bytes[1], bytes[2][5:0]);
    end
    @(negedge clk);
    tx_full = 1'b0;
    wait_push(t0 + 20, 300, "rand_wait");
    exp_frames += 20;
    for (int f = 0; f < 20; f++) begin
      if (tx_log[(t0 + f) % 2048] !== exp[f]) begin
        bad++;
        $display("FAIL rand_frame_%0d: pushed %h required %h", f, tx_log[(t0 + f) % 2048], exp[f]);
      end
    end
    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (frame_cnt !== exp_frames[7:0]) begin
      n_fail++;
      $display("FAIL rand_frames: frame_cnt=%0d required %0d", frame_cnt, exp_frames[7:0]);
    end
  endtask

  task automatic test_async_reset();
    int t0;
    send_byte(8'h11); send_byte(8'h22);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || alu_a !== 8'h00 || alu_b !== 8'h00 || tx_data !== 8'h00 || frame_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_clear: busy=%b a=%h b=%h data=%h frames=%h required all 0",
               busy, alu_a, alu_b, tx_data, frame_cnt);
    end
    exp_frames = 0;
    @(negedge clk);
    rst_n = 1'b1;
    t0 = push_cnt;
    send_byte(8'h03); send_byte(8'h05); send_byte(8'h22);
    wait_push(t0 + 1, 20, "areset_wait");
    exp_frames++;
    n_checks++;
    if (tx_log[t0[10:0]] !== 8'hFE || alu_a !== 8'h03 || frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL areset_frame: data=%h a=%h frames=%0d required fe 03 1", tx_log[t0[10:0]], alu_a, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    int need = 255 - (exp_frames % 256);
    for (int f = 0; f < need; f++) begin
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
      wait_push(push_cnt + 1, 20, "wrap_wait");
      exp_frames++;
    end
    n_checks++;
    if (frame_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_max: frame_cnt=%0d required 255", frame_cnt);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    wait_push(push_cnt + 1, 20, "wrap_wait");
    exp_frames++;
    n_checks++;
    if (frame_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_zero: frame_cnt=%0d required 0", frame_cnt);
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t0 = push_cnt;
    int pulses = 0;
    send_byte(8'h44);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1 || busy !== 1'b0 || push_cnt != t0) begin
      n_fail++;
      $display("FAIL timeout_abort: pulses=%0d busy=%b pushes=%0d required 1 0 0", pulses, busy, push_cnt - t0);
    end
    send_byte(8'h09); send_byte(8'h06); send_byte(8'h22);
    wait_push(t0 + 1, 20, "timeout_wait");
    exp_frames++;
    n_checks++;
    if (tx_log[t0[10:0]] !== 8'h03 || frame_cnt !== exp_frames[7:0]) begin
      n_fail++;
      $display("FAIL timeout_next: data=%h frames=%0d required 03 %0d", tx_log[t0[10:0]], frame_cnt, exp_frames[7:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_rx_gaps();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_wrap();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (bad_pop != 0) begin
      n_fail++;
      $display("FAIL pop_when_empty: %0d pops while empty, required 0", bad_pop);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
